// File: rtl/brq_rf_pkg.sv
// Shared defaults and types for the register-file writeback scheduler.
package brq_rf_pkg;

  localparam int DefDataWidth    = 32;
  localparam int DefAddrRegWidth = 5;
  localparam int DefNregs        = 2 ** DefAddrRegWidth;
  localparam int DefNumReq       = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [DefAddrRegWidth-1:0] rd;
    logic [DefDataWidth-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: zero-latency grant, search starts one past the last winner.
module rr_arbiter #(
  parameter  int N    = 3,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int idx;
    logic [IdxW-1:0] cand;
    idx     = 0;
    cand    = '0;
    gnt     = '0;
    gnt_idx = '0;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        cand = IdxW'(idx);
        if (gnt == '0 && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && (|gnt)) rr_ptr_d = gnt_idx;
  end

  // Pointer parks on the last index so requester 0 is first after reset.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= IdxW'(N - 1);
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the RegFile write port among writeback units and tracks per-register
// busy bits so issue can stall on RAW/WAW hazards.
module rf_wb_scheduler
  import brq_rf_pkg::*;
#(
  parameter  int DataWidth    = DefDataWidth,
  parameter  int AddrRegWidth = DefAddrRegWidth,
  parameter  int NumReq       = DefNumReq,
  localparam int NREGS        = 2 ** AddrRegWidth,
  localparam int IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                           brq_clk,
  input  logic                           brq_rst,
  input  logic [NumReq-1:0]              req_valid,
  input  logic [NumReq*AddrRegWidth-1:0] req_rd,
  input  logic [NumReq*DataWidth-1:0]    req_data,
  output logic [NumReq-1:0]              req_ready,
  input  logic                           issue_en,
  input  logic [AddrRegWidth-1:0]        issue_rd,
  input  logic [AddrRegWidth-1:0]        issue_rs1,
  input  logic [AddrRegWidth-1:0]        issue_rs2,
  output logic                           issue_stall,
  output logic                           writeEn,
  output logic [AddrRegWidth-1:0]        writeDataSel,
  output logic [DataWidth-1:0]           writeData,
  output logic [NREGS-1:0]               busy_vec
);

  typedef struct packed {
    logic [AddrRegWidth-1:0] rd;
    logic [DataWidth-1:0]    data;
  } req_t;

  req_t            reqs [NumReq];
  req_t            sel;
  logic [IdxW-1:0] gnt_idx;
  logic            grant;
  logic [NREGS-1:0] busy_q, busy_d;

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign reqs[g] = {req_rd[g*AddrRegWidth +: AddrRegWidth], req_data[g*DataWidth +: DataWidth]};
  end

  rr_arbiter #(.N(NumReq)) u_arb (
    .clk     (brq_clk),
    .rst     (brq_rst),
    .req     (req_valid),
    .advance (1'b1),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  // A granted write to x0 still completes the handshake but never reaches RegFile.
  always_comb begin
    grant        = |req_ready;
    sel          = reqs[gnt_idx];
    writeEn      = grant && (sel.rd != '0);
    writeDataSel = grant ? sel.rd : '0;
    writeData    = grant ? sel.data : '0;
  end

  assign issue_stall = issue_en & (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
  assign busy_vec    = busy_q;

  always_comb begin
    busy_d = busy_q;
    busy_d[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      busy_d[r] = (issue_en && !issue_stall && issue_rd == AddrRegWidth'(r)) ||
                  (busy_q[r] && !(writeEn && writeDataSel == AddrRegWidth'(r)));
    end
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  for (genvar i = 0; i < NumReq; i++) begin : g_hold
    a_req_stable: assert property (@(posedge brq_clk) disable iff (brq_rst)
      (!brq_rst && req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_rd[i*AddrRegWidth +: AddrRegWidth]) &&
         $stable(req_data[i*DataWidth +: DataWidth])));
  end

  // Writeback to a register nobody reserved: legal, but worth seeing in coverage.
  c_wb_unowned: cover property (@(posedge brq_clk) disable iff (brq_rst)
    writeEn && !busy_q[writeDataSel]);

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed vector bench for rf_wb_scheduler: arbitration, write port and scoreboard.
module tb_rf_wb_scheduler;
  import brq_rf_pkg::*;

  logic        brq_clk = 1'b0;
  logic        brq_rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        issue_en;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        writeEn;
  logic [4:0]  writeDataSel;
  logic [31:0] writeData;
  logic [31:0] busy_vec;

  always #5 brq_clk = ~brq_clk;

  rf_wb_scheduler dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall), .writeEn(writeEn), .writeDataSel(writeDataSel),
    .writeData(writeData), .busy_vec(busy_vec)
  );

  typedef struct {
    bit          rst;
    logic [2:0]  v;
    logic [14:0] rd;
    logic [95:0] dt;
    bit          ien;
    logic [4:0]  ird, irs1, irs2;
    logic [2:0]  e_rdy;
    bit          e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_dat;
    bit          e_stall;
    bit          cb;
    logic [31:0] e_busy;
  } vec_t;

  localparam logic [14:0] RR_RD  = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] RR_DT  = {32'hC, 32'hB, 32'hA};
  localparam logic [14:0] Z_RD   = 15'd0;
  localparam logic [95:0] Z_DT   = 96'd0;
  localparam logic [14:0] L5_RD  = {5'd0, 5'd5, 5'd0};
  localparam logic [95:0] L5_DT  = {32'd0, 32'h1234, 32'd0};
  localparam logic [14:0] M7_RD  = {5'd7, 5'd0, 5'd0};
  localparam logic [95:0] M7_DT  = {32'h77, 64'd0};
  localparam logic [95:0] A0_DT  = {64'd0, 32'hFFFF_FFFF};
  localparam logic [14:0] L10_RD = {5'd0, 5'd10, 5'd0};
  localparam logic [95:0] L10_DT = {32'd0, 32'h55, 32'd0};
  localparam logic [14:0] P_RD   = {5'd13, 5'd12, 5'd11};
  localparam logic [95:0] P_DT   = {32'd3, 32'd2, 32'd1};

  vec_t vq[$];
  int   applied = 0;
  int   ncmp    = 0;
  int   miscmp  = 0;

  function automatic vec_t mk(bit rst, logic [2:0] v, logic [14:0] rd, logic [95:0] dt,
                              bit ien, logic [4:0] ird, logic [4:0] irs1, logic [4:0] irs2,
                              logic [2:0] erdy, bit ewe, logic [4:0] esel, logic [31:0] edat,
                              bit est, bit cb, logic [31:0] ebusy);
    vec_t t;
    t.rst = rst; t.v = v; t.rd = rd; t.dt = dt;
    t.ien = ien; t.ird = ird; t.irs1 = irs1; t.irs2 = irs2;
    t.e_rdy = erdy; t.e_we = ewe; t.e_sel = esel; t.e_dat = edat;
    t.e_stall = est; t.cb = cb; t.e_busy = ebusy;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      miscmp++;
      $display("FAIL step%0d %s: got %0h want %0h", idx, nm, got, want);
    end
  endtask

  task automatic drive(input vec_t t);
    brq_rst   = t.rst;
    req_valid = t.v;
    req_rd    = t.rd;
    req_data  = t.dt;
    issue_en  = t.ien;
    issue_rd  = t.ird;
    issue_rs1 = t.irs1;
    issue_rs2 = t.irs2;
  endtask

  initial begin
    brq_rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    issue_en = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;

    // reset held with everyone valid
    vq.push_back(mk(1, 3'b111, RR_RD, RR_DT, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 0, 32'h0));
    vq.push_back(mk(1, 3'b111, RR_RD, RR_DT, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 1, 32'h0));
    // round-robin 0,1,2,0 then drain; issues populate the scoreboard
    vq.push_back(mk(0, 3'b111, RR_RD, RR_DT, 1, 4, 0, 0, 3'b001, 1, 1, 32'hA, 0, 1, 32'h0));
    vq.push_back(mk(0, 3'b111, RR_RD, RR_DT, 1, 6, 4, 0, 3'b010, 1, 2, 32'hB, 1, 1, 32'h10));
    vq.push_back(mk(0, 3'b111, RR_RD, RR_DT, 0, 0, 0, 0, 3'b100, 1, 3, 32'hC, 0, 1, 32'h10));
    vq.push_back(mk(0, 3'b111, RR_RD, RR_DT, 1, 5, 1, 2, 3'b001, 1, 1, 32'hA, 0, 1, 32'h10));
    vq.push_back(mk(0, 3'b110, RR_RD, RR_DT, 0, 0, 0, 0, 3'b010, 1, 2, 32'hB, 0, 1, 32'h30));
    vq.push_back(mk(0, 3'b100, RR_RD, RR_DT, 0, 0, 0, 0, 3'b100, 1, 3, 32'hC, 0, 1, 32'h30));
    // RAW on x5, cleared by LSU writeback, no same-cycle bypass
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 1, 8, 5, 0, 3'b000, 0, 0, 32'h0, 1, 1, 32'h30));
    vq.push_back(mk(0, 3'b010, L5_RD, L5_DT, 1, 8, 5, 0, 3'b010, 1, 5, 32'h1234, 1, 1, 32'h30));
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 1, 8, 5, 0, 3'b000, 0, 0, 32'h0, 0, 1, 32'h10));
    // set/clear collision on x7
    vq.push_back(mk(0, 3'b100, M7_RD, M7_DT, 1, 7, 0, 0, 3'b100, 1, 7, 32'h77, 0, 1, 32'h110));
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 1, 32'h190));
    // x0 writeback dropped, x0 issue never reserves
    vq.push_back(mk(0, 3'b001, Z_RD, A0_DT, 1, 0, 0, 0, 3'b001, 0, 0, 32'hFFFF_FFFF, 0, 1, 32'h190));
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 0, 7, 7, 0, 3'b000, 0, 0, 32'h0, 0, 1, 32'h190));
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 1, 7, 0, 0, 3'b000, 0, 0, 32'h0, 1, 1, 32'h190));
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 1, 10, 0, 8, 3'b000, 0, 0, 32'h0, 1, 1, 32'h190));
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 1, 3, 0, 0, 3'b000, 0, 0, 32'h0, 0, 1, 32'h190));
    vq.push_back(mk(0, 3'b000, Z_RD, Z_DT, 1, 9, 0, 0, 3'b000, 0, 0, 32'h0, 0, 1, 32'h198));
    // mid-operation reset with LSU pending
    vq.push_back(mk(1, 3'b010, L10_RD, L10_DT, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0, 0, 1, 32'h398));
    vq.push_back(mk(0, 3'b111, P_RD, P_DT, 0, 0, 0, 0, 3'b001, 1, 11, 32'd1, 0, 1, 32'h0));
    vq.push_back(mk(0, 3'b110, P_RD, P_DT, 0, 0, 0, 0, 3'b010, 1, 12, 32'd2, 0, 1, 32'h0));
    vq.push_back(mk(0, 3'b100, P_RD, P_DT, 0, 0, 0, 0, 3'b100, 1, 13, 32'd3, 0, 1, 32'h0));

    @(posedge brq_clk); #1;
    foreach (vq[i]) begin
      drive(vq[i]);
      applied++;
      @(negedge brq_clk);
      chk("req_ready", i, 32'(req_ready), 32'(vq[i].e_rdy));
      chk("writeEn", i, 32'(writeEn), 32'(vq[i].e_we));
      chk("writeDataSel", i, 32'(writeDataSel), 32'(vq[i].e_sel));
      chk("writeData", i, writeData, vq[i].e_dat);
      chk("issue_stall", i, 32'(issue_stall), 32'(vq[i].e_stall));
      if (vq[i].cb) chk("busy_vec", i, busy_vec, vq[i].e_busy);
      @(posedge brq_clk); #1;
    end

    // Fairness: six cycles all valid, each requester granted once per three cycles.
    begin
      int cnt [3];
      logic [2:0] want;
      cnt = '{0, 0, 0};
      for (int k = 0; k < 6; k++) begin
        drive(mk(0, 3'b111, RR_RD, RR_DT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        applied++;
        want = 3'b001 << (k % 3);
        @(negedge brq_clk);
        chk("fair_ready", 100 + k, 32'(req_ready), 32'(want));
        chk("fair_data", 100 + k, writeData, 32'hA + 32'(k % 3));
        for (int j = 0; j < 3; j++) if (req_ready[j]) cnt[j]++;
        @(posedge brq_clk); #1;
      end
      chk("fair_cnt_alu", 106, 32'(cnt[WB_ALU]), 32'd2);
      chk("fair_cnt_lsu", 106, 32'(cnt[WB_LSU]), 32'd2);
      chk("fair_cnt_mdu", 106, 32'(cnt[WB_MDU]), 32'd2);
      // drain the two still-pending requesters
      drive(mk(0, 3'b011, RR_RD, RR_DT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
      applied++;
      @(negedge brq_clk);
      chk("drain_ready0", 107, 32'(req_ready), 32'h1);
      @(posedge brq_clk); #1;
      drive(mk(0, 3'b010, RR_RD, RR_DT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
      applied++;
      @(negedge brq_clk);
      chk("drain_ready1", 108, 32'(req_ready), 32'h2);
      @(posedge brq_clk); #1;
      req_valid = '0;
      @(posedge brq_clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Shares the register file's single write port between NumReq writeback requesters (ALU, LSU, MDU) using round-robin arbitration with valid/ready handshakes.
Also keeps a per-register busy scoreboard that is set at issue and cleared at writeback. Issue uses it to stall on RAW/WAW hazards.
Sits between the execute/memory units and RegFile, driving its writeEn, writeDataSel and writeData.

Parameters:
DataWidth, 32, register data width
AddrRegWidth, 5, register index width; NREGS = 2**AddrRegWidth
NumReq, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = MDU)

Ports:
brq_clk  input  1  clock; all state updates on its rising edge
brq_rst  input  1  synchronous active-high reset
req_valid  input  NumReq  requester i holds a writeback
req_rd  input  NumReq*AddrRegWidth  destination index, requester i at slice [i*AddrRegWidth +: AddrRegWidth]
req_data  input  NumReq*DataWidth  write data, same slicing
req_ready  output  NumReq  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
issue_en  input  1  issue stage attempts to issue an instruction this cycle
issue_rd  input  AddrRegWidth  destination of the issuing instruction
issue_rs1  input  AddrRegWidth  source 1
issue_rs2  input  AddrRegWidth  source 2
issue_stall  output  1  instruction must not issue this cycle
writeEn  output  1  RegFile write enable
writeDataSel  output  AddrRegWidth  RegFile write index
writeData  output  DataWidth  RegFile write data
busy_vec  output  NREGS  current scoreboard, for debug and verification

Behaviour:
- Reset is synchronous on brq_rst=1:
  - busy_vec clears to 0.
  - rr_ptr (last granted index) goes to NumReq-1, so requester 0 wins first after reset.
  - Write-port outputs follow their combinational definition, so writeEn=0 while brq_rst=1.
- Arbitration is combinational with zero latency:
  - Search starts at (rr_ptr+1) mod NumReq; the first asserted req_valid is granted.
  - req_ready is at most one-hot, and is 0 for every requester whose req_valid=0.
  - While brq_rst=1, all req_ready=0.
- On a grant g, in the same cycle:
  - writeEn = (req_rd[g] != 0); writes to x0 are dropped at this block.
  - writeDataSel = req_rd[g]; writeData = req_data[g].
  - rr_ptr <= g at the clock edge.
- With no grant: writeEn=0, writeDataSel=0, writeData=0, and rr_ptr holds.
- Handshake rules: a requester keeps req_valid, req_rd and req_data stable until granted. Stability is checked by assertion, not corrected by the block.
- Fairness: with all requesters continuously valid, each is granted exactly once every NumReq cycles.
- Hazard check: issue_stall = issue_en & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]).
  - busy[0] is constant 0, so x0 never stalls.
  - The check uses the registered scoreboard only; there is no same-cycle bypass of a clear.
- Scoreboard next state for each index r != 0:
  - set = issue_en & ~issue_stall & (issue_rd == r)
  - clr = writeEn & (writeDataSel == r)
  - busy[r] <= set | (busy[r] & ~clr); if set and clr hit the same r in one cycle, set wins.
- Writeback without busy: a writeback to a register whose busy bit is clear is still written. The bit stays clear, and an assertion flags it.
- Reset mid-operation:
  - Pending requests are dropped and the scoreboard is flushed.
  - Requesters are also reset by brq_rst, so no stale grant is issued.
- Size: about 150–250 lines of RTL.

Decomposition:
- Package brq_rf_pkg holds:
  - DataWidth and AddrRegWidth defaults, NREGS
  - enum wb_src_e {WB_ALU=0, WB_LSU=1, WB_MDU=2}
  - typedef wb_req_t {rd, data}
- Sub-module rr_arbiter, parameterised by N:
  - Inputs: req[N], advance, clock and reset.
  - Outputs: gnt[N] one-hot and gnt_idx.
  - It owns rr_ptr.
- The top level holds the scoreboard, the hazard check and the write-port mux.

Test Plan:
- Reset: hold brq_rst=1 for 2 cycles with all req_valid=1 -> req_ready=000, writeEn=0, busy_vec=0. In the first cycle after reset with all valid, requester 0 is granted.
- Round-robin: all three valid, rd=1/2/3, data=0xA/0xB/0xC -> grants cycle through 0,1,2,0. writeDataSel/writeData are 1/0xA, 2/0xB, 3/0xC.
- RAW stall: issue rd=5 (busy[5]=1), then issue rs1=5 -> issue_stall=1 until the cycle after LSU writeback to x5 with data 0x1234. The next issue proceeds with stall=0.
- Set/clear collision: in one cycle MDU writes back x7 and a new issue targets rd=7 (busy[7] was clear) -> writeEn=1 to x7 and busy[7]=1 afterwards.
- x0 handling: ALU request with rd=0, data=0xFFFFFFFF -> req_ready[0]=1 and writeEn=0. Issuing rd=0 never sets busy_vec[0] and never stalls.
- Mid-operation reset: busy bits 3 and 9 set and LSU valid; assert brq_rst for 1 cycle -> busy_vec=0, no write that cycle, and requester 0 has priority after reset.
